cache_lookup_ctrl: RTL and testbench



---
 rtl/cache_lookup_ctrl_pkg.sv | 44 ++++
 rtl/cache_lookup_ctrl_plru.sv | 37 +++
 rtl/cache_lookup_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_cache_lookup_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_lookup_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_lookup_ctrl_pkg
// Shared definitions for the read-path lookup control of the 4-way cache
// with 32-byte lines: controller state encoding, geometry constants, and
// small address-split and way helper functions.
// ---------------------------------------------------------------------------
package cache_lookup_ctrl_pkg;

  localparam int OFFSET_BITS = 5;
  localparam int WAYS        = 4;

  localparam logic [31:0] LINE_MASK = 32'h0000_001F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    REFILL  = 2'd2,
    REREAD  = 2'd3
  } state_t;

  // Byte offset within the line.
  function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [31:0] addr);
    return OFFSET_BITS'(addr & LINE_MASK);
  endfunction

  // Line-aligned address, i.e. {tag, set, 5'b0}.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & ~LINE_MASK;
  endfunction

  // Two-bit way number to one-hot write enable.
  function automatic logic [WAYS-1:0] way_onehot(input logic [1:0] way);
    return 4'b0001 << way;
  endfunction

  // Lowest-numbered way whose valid bit is clear; 3 if all are valid.
  function automatic logic [1:0] first_invalid(input logic [WAYS-1:0] valid);
    if (!valid[0])      return 2'd0;
    else if (!valid[1]) return 2'd1;
    else if (!valid[2]) return 2'd2;
    else                return 2'd3;
  endfunction

endpackage

// File: rtl/cache_lookup_ctrl_plru.sv
// ---------------------------------------------------------------------------
// plru_tree4
// Combinational tree pseudo-LRU for one 4-way set entry.
//   bit0 : which half holds the victim (0 -> ways 0/1, 1 -> ways 2/3)
//   bit1 : victim within ways 0/1 (0 -> way0, 1 -> way1)
//   bit2 : victim within ways 2/3 (0 -> way2, 1 -> way3)
// Ports:
//   i_plru        current 3-bit tree state of the set
//   i_access_way  way being hit or filled
//   o_victim      way the tree currently points at
//   o_plru_next   tree state after touching i_access_way
// ---------------------------------------------------------------------------
module plru_tree4 (
  input  logic [2:0] i_plru,
  input  logic [1:0] i_access_way,
  output logic [1:0] o_victim,
  output logic [2:0] o_plru_next
);

  always_comb begin
    o_victim = i_plru[0] ? {1'b1, i_plru[2]} : {1'b0, i_plru[1]};
  end

  // Touching a way points the root at the other half and the half's
  // leaf bit at the sibling way; the other leaf is left alone.
  always_comb begin
    o_plru_next = i_plru;
    if (!i_access_way[1]) begin
      o_plru_next[0] = 1'b1;
      o_plru_next[1] = ~i_access_way[0];
    end else begin
      o_plru_next[0] = 1'b0;
      o_plru_next[2] = ~i_access_way[0];
    end
  end

endmodule

// File: rtl/cache_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// cache_lookup_ctrl
// Read-path control stage of a 4-way, 32-byte-line cache. Accepts UFP read
// requests, owns per-set valid bits and pseudo-LRU trees, compares the way
// tags, drives the downstream word mux, and runs a DFP line refill on a
// miss, writing the returned line into the victim way.
//
// Optional build macro: CACHE_PERF_CNT_EN adds saturating hit_count and
// miss_count outputs.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   ufp_addr       request byte address
//   ufp_rmask      byte read mask, non-zero marks a request
//   ufp_resp       one-cycle response strobe
//   arr_index      set index to the tag/data arrays
//   arr_tag        way tags, valid one cycle after arr_index
//   arr_we         one-hot way write enable on refill
//   arr_wtag       tag written on refill
//   line_select    hit way to the word mux
//   offset, rmask  latched request offset and mask to the word mux
//   dfp_addr       line-aligned refill address
//   dfp_read       refill request, held until dfp_resp
//   hit_count, miss_count  (CACHE_PERF_CNT_EN only)
//   dfp_resp       refill data returned
// ---------------------------------------------------------------------------
module cache_lookup_ctrl
  import cache_lookup_ctrl_pkg::*;
#(
  parameter int SET_BITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 ufp_addr,
  input  logic [3:0]                  ufp_rmask,
  output logic                        ufp_resp,
  output logic [SET_BITS-1:0]         arr_index,
  input  logic [4*(27-SET_BITS)-1:0]  arr_tag,
  output logic [3:0]                  arr_we,
  output logic [27-SET_BITS-1:0]      arr_wtag,
  output logic [1:0]                  line_select,
  output logic [4:0]                  offset,
  output logic [3:0]                  rmask,
  output logic [31:0]                 dfp_addr,
  output logic                        dfp_read,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count,
`endif
  input  logic                        dfp_resp
);

  localparam int TAG_BITS = 27 - SET_BITS;
  localparam int SETS     = 2 ** SET_BITS;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]         r_addr;
  logic [3:0]          r_rmask;
  logic [WAYS-1:0]     r_valid [SETS];
  logic [2:0]          r_plru  [SETS];

  logic [TAG_BITS-1:0] w_req_tag;
  logic [SET_BITS-1:0] w_req_set;
  logic [WAYS-1:0]     w_hit;
  logic                w_hit_any;
  logic [1:0]          w_hit_way;
  logic [1:0]          w_plru_victim;
  logic [1:0]          w_victim;
  logic [1:0]          w_access_way;
  logic [2:0]          w_plru_next;
  logic                w_accept;
  logic                w_plru_we;
  logic                w_fill;

  assign w_req_tag = r_addr[31:OFFSET_BITS+SET_BITS];
  assign w_req_set = r_addr[OFFSET_BITS+SET_BITS-1:OFFSET_BITS];
  assign arr_wtag  = w_req_tag;
  assign offset    = addr_offset(r_addr);
  assign rmask     = r_rmask;

  always_comb begin
    w_hit = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit[w] = r_valid[w_req_set][w] &&
                 (arr_tag[w*TAG_BITS +: TAG_BITS] == w_req_tag);
    end
  end

  assign w_hit_any = |w_hit;

  always_comb begin
    casez (w_hit)
      4'b???1: w_hit_way = 2'd0;
      4'b??10: w_hit_way = 2'd1;
      4'b?100: w_hit_way = 2'd2;
      4'b1000: w_hit_way = 2'd3;
      default: w_hit_way = 2'd0;
    endcase
  end

  // Invalid ways are filled first so a cold set never evicts live data.
  assign w_victim     = (&r_valid[w_req_set]) ? w_plru_victim
                                              : first_invalid(r_valid[w_req_set]);
  assign w_access_way = w_fill ? w_victim : w_hit_way;

  plru_tree4 u_plru (
    .i_plru       (r_plru[w_req_set]),
    .i_access_way (w_access_way),
    .o_victim     (w_plru_victim),
    .o_plru_next  (w_plru_next)
  );

  // Next state and all combinational outputs. The array index follows the
  // incoming request whenever one can be accepted this cycle so that its
  // tags arrive in time for the following COMPARE.
  always_comb begin
    w_next_state = r_state;
    ufp_resp     = 1'b0;
    line_select  = 2'd0;
    arr_we       = '0;
    dfp_read     = 1'b0;
    dfp_addr     = '0;
    arr_index    = w_req_set;
    w_accept     = 1'b0;
    w_plru_we    = 1'b0;
    w_fill       = 1'b0;
    unique case (r_state)
      IDLE: begin
        arr_index = ufp_addr[OFFSET_BITS+SET_BITS-1:OFFSET_BITS];
        if (ufp_rmask != 4'd0) begin
          w_accept     = 1'b1;
          w_next_state = COMPARE;
        end
      end
      COMPARE: begin
        if (w_hit_any) begin
          ufp_resp    = 1'b1;
          line_select = w_hit_way;
          w_plru_we   = 1'b1;
          if (ufp_rmask != 4'd0) begin
            w_accept     = 1'b1;
            arr_index    = ufp_addr[OFFSET_BITS+SET_BITS-1:OFFSET_BITS];
            w_next_state = COMPARE;
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          w_next_state = REFILL;
        end
      end
      REFILL: begin
        dfp_read = 1'b1;
        dfp_addr = line_base(r_addr);
        if (dfp_resp) begin
          arr_we       = way_onehot(w_victim);
          w_fill       = 1'b1;
          w_plru_we    = 1'b1;
          w_next_state = REREAD;
        end
      end
      REREAD: begin
        w_next_state = COMPARE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_rmask <= '0;
    end else if (w_accept) begin
      r_addr  <= ufp_addr;
      r_rmask <= ufp_rmask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if (w_fill) begin
        r_valid[w_req_set][w_victim] <= 1'b1;
      end
      if (w_plru_we) begin
        r_plru[w_req_set] <= w_plru_next;
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic r_post_fill;

  // The COMPARE following REREAD is the refill's own guaranteed hit and
  // is not counted as a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_post_fill <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      r_post_fill <= (r_state == REREAD);
      if (r_state == COMPARE) begin
        if (w_hit_any && !r_post_fill && (hit_count != 32'hFFFF_FFFF)) begin
          hit_count <= hit_count + 32'd1;
        end
        if (!w_hit_any && (miss_count != 32'hFFFF_FFFF)) begin
          miss_count <= miss_count + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_lookup_ctrl
// Self-checking bench for cache_lookup_ctrl. A behavioural tag array sits on
// the arr_* interface; directed requests push their expected word-mux
// response into a queue and a negedge monitor pops and compares whenever
// the DUT raises ufp_resp. Latency, refill address and write-enable checks
// are made by the stimulus tasks themselves.
// ---------------------------------------------------------------------------
module tb_cache_lookup_ctrl;
  import cache_lookup_ctrl_pkg::*;

  localparam int SET_BITS = 4;
  localparam int TW       = 27 - SET_BITS;
  localparam int SETS     = 2 ** SET_BITS;

  logic              clk;
  logic              rst_n;
  logic [31:0]       ufp_addr;
  logic [3:0]        ufp_rmask;
  logic              ufp_resp;
  logic [SET_BITS-1:0] arr_index;
  logic [4*TW-1:0]   arr_tag;
  logic [3:0]        arr_we;
  logic [TW-1:0]     arr_wtag;
  logic [1:0]        line_select;
  logic [4:0]        offset;
  logic [3:0]        rmask;
  logic [31:0]       dfp_addr;
  logic              dfp_read;
  logic              dfp_resp;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;
`endif

  cache_lookup_ctrl #(.SET_BITS(SET_BITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ufp_addr    (ufp_addr),
    .ufp_rmask   (ufp_rmask),
    .ufp_resp    (ufp_resp),
    .arr_index   (arr_index),
    .arr_tag     (arr_tag),
    .arr_we      (arr_we),
    .arr_wtag    (arr_wtag),
    .line_select (line_select),
    .offset      (offset),
    .rmask       (rmask),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
`ifdef CACHE_PERF_CNT_EN
    .hit_count   (hit_count),
    .miss_count  (miss_count),
`endif
    .dfp_resp    (dfp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural tag array: registered read, written on arr_we.
  logic [TW-1:0] tagMem [SETS][4];
  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      arr_tag[w*TW +: TW] <= tagMem[arr_index][w];
      if (arr_we[w]) tagMem[arr_index][w] <= arr_wtag;
    end
  end

  typedef struct packed {
    logic [1:0] way;
    logic [4:0] off;
    logic [3:0] rm;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && ufp_resp) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("respLineSelect", 32'(line_select), 32'(e.way));
        checkOutput("respOffset",     32'(offset),      32'(e.off));
        checkOutput("respRmask",      32'(rmask),       32'(e.rm));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && dut.r_state == COMPARE)
      assert ($onehot0(dut.w_hit)) else $error("[TB] more than one way hit");
  end

  task automatic applyReset();
    rst_n     = 1'b0;
    ufp_rmask = 4'd0;
    dfp_resp  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
  endtask

  // One request; the bench answers a refill three cycles after dfp_read.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] rm,
                               input bit expMiss, input logic [1:0] expWay);
    int cyc, respCyc, fillCyc, readCycles;
    bit done, sawRead;
    exp_t e;
    @(negedge clk);
    ufp_addr  = addr;
    ufp_rmask = rm;
    e.way = expWay; e.off = addr[4:0]; e.rm = rm;
    expQ.push_back(e);
    cyc = 0; respCyc = 0; fillCyc = -100; readCycles = 0;
    done = 1'b0; sawRead = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      dfp_resp = 1'b0;
      if (ufp_resp) begin
        done      = 1'b1;
        respCyc   = cyc;
        ufp_rmask = 4'd0;
      end else if (dfp_read) begin
        sawRead = 1'b1;
        readCycles++;
        checkOutput("dfpAddrHeld", dfp_addr, addr & 32'hFFFF_FFE0);
        if (readCycles == 3) begin
          dfp_resp = 1'b1;
          fillCyc  = cyc;
          #1 checkOutput("arrWeVictim", 32'(arr_we), 32'(4'b0001 << expWay));
        end
      end
    end
    checkOutput("respArrived", 32'(done), 32'd1);
    checkOutput("missPath", 32'(sawRead), 32'(expMiss));
    if (done)
      checkOutput("respLatency", expMiss ? 32'(respCyc - fillCyc) : 32'(respCyc),
                  expMiss ? 32'd2 : 32'd1);
    else begin
      ufp_rmask = 4'd0;
      expQ.delete();
    end
  endtask

  logic [31:0] burstAddr [3];
  logic [3:0]  burstMask [3];

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    ufp_addr  = '0;
    ufp_rmask = '0;
    dfp_resp  = 1'b0;
    burstAddr[0] = 32'h0000_1040; burstMask[0] = 4'hF;
    burstAddr[1] = 32'h0000_1044; burstMask[1] = 4'h3;
    burstAddr[2] = 32'h0000_1048; burstMask[2] = 4'hC;

    repeat (2) @(negedge clk);
    checkOutput("rstDfpRead", 32'(dfp_read), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstUfpResp",    32'(ufp_resp),    32'd0);
    checkOutput("rstArrWe",      32'(arr_we),      32'd0);
    checkOutput("rstLineSelect", 32'(line_select), 32'd0);
    checkOutput("rstDfpAddr",    dfp_addr,         32'd0);
    checkOutput("rstOffset",     32'(offset),      32'd0);

    // Cold miss into way0, then an immediate hit on the same line.
    applyStimulus(32'h0000_1040, 4'hF, 1'b1, 2'd0);
    applyStimulus(32'h0000_1040, 4'hF, 1'b0, 2'd0);

    // Back-to-back hits within the line.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e.way = 2'd0; e.off = burstAddr[i][4:0]; e.rm = burstMask[i];
      expQ.push_back(e);
    end
    ufp_addr  = burstAddr[0];
    ufp_rmask = burstMask[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("burstResp", 32'(ufp_resp), 32'd1);
      checkOutput("burstNoRead", 32'(dfp_read), 32'd0);
      if (i < 2) begin
        ufp_addr  = burstAddr[i+1];
        ufp_rmask = burstMask[i+1];
      end else begin
        ufp_rmask = 4'd0;
      end
    end

    // Five tags into set 2 from a clean cache.
    applyReset();
    applyStimulus(32'h0000_0240, 4'hF, 1'b1, 2'd0);
    applyStimulus(32'h0000_0440, 4'hF, 1'b1, 2'd1);
    applyStimulus(32'h0000_0640, 4'h1, 1'b1, 2'd2);
    applyStimulus(32'h0000_0840, 4'h2, 1'b1, 2'd3);
    applyStimulus(32'h0000_0A44, 4'hF, 1'b1, 2'd0);
    applyStimulus(32'h0000_0448, 4'hF, 1'b0, 2'd1);
    applyStimulus(32'h0000_0240, 4'hF, 1'b1, 2'd2);

    // Reset while a refill is outstanding.
    @(negedge clk);
    ufp_addr  = 32'h0000_3000;
    ufp_rmask = 4'hF;
    for (int i = 0; i < 10 && !dfp_read; i++) @(negedge clk);
    checkOutput("midRefillRead", 32'(dfp_read), 32'd1);
    #2 rst_n = 1'b0;
    ufp_rmask = 4'd0;
    #1;
    checkOutput("asyncDropRead", 32'(dfp_read), 32'd0);
    checkOutput("asyncDfpAddr",  dfp_addr,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();

    applyStimulus(32'h0000_0240, 4'hF, 1'b1, 2'd0);
    applyStimulus(32'h0000_0240, 4'hF, 1'b0, 2'd0);
    applyStimulus(32'h0000_0244, 4'h3, 1'b0, 2'd0);
    applyStimulus(32'h0000_025C, 4'h8, 1'b0, 2'd0);

`ifdef CACHE_PERF_CNT_EN
    @(negedge clk);
    checkOutput("missCount", miss_count, 32'd1);
    checkOutput("hitCount",  hit_count,  32'd3);
`endif

    repeat (2) @(negedge clk);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
